// File: rtl/logic_gates_pkg.sv
// Shared definitions for the two-input gate unit self-test sequencer:
// state encoding, step count and the reference truth table.
package logic_gates_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } seq_state_e;

    localparam int         NUM_STEPS = 4;
    localparam logic [1:0] LAST_STEP = 2'(NUM_STEPS - 1);

    // Reference gate behaviour, packed as {and, or, not}.
    function automatic logic [2:0] gate_expect(input logic a, input logic b);
        return {a & b, a | b, ~a};
    endfunction

endpackage

// File: rtl/logic_gates_expect.sv
// Combinational comparator: flags when the observed gate outputs differ
// from the reference truth table for the applied (A,B).
module logic_gates_expect (
    input  logic a_i,
    input  logic b_i,
    input  logic and_i,
    input  logic or_i,
    input  logic not_i,
    output logic mismatch_o
);
    import logic_gates_pkg::*;

    logic [2:0] exp_w;

    always_comb begin
        exp_w      = gate_expect(a_i, b_i);
        mismatch_o = (exp_w != {and_i, or_i, not_i});
    end

endmodule

// File: rtl/logic_gates_seq.sv
// Self-test sequencer: walks the four (A,B) combinations, waits a settle
// time on each, checks the gate unit outputs and reports a fail mask.
module logic_gates_seq #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iStart,
    input  logic       iAnd,
    input  logic       iOr,
    input  logic       iNot,
    output logic       oA,
    output logic       oB,
    output logic [1:0] oStep,
    output logic       oBusy,
    output logic       oDone,
    output logic       oPass,
    output logic [3:0] oFailMask
);
    import logic_gates_pkg::*;

    localparam int            CW       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    seq_state_e    state_q, state_d;
    logic [1:0]    step_q, step_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    mask_q, mask_d;
    logic          pass_q, pass_d;
    logic          mismatch_w;

    // The step index doubles as the applied (A,B) pair during CHECK.
    logic_gates_expect u_expect (
        .a_i        (step_q[0]),
        .b_i        (step_q[1]),
        .and_i      (iAnd),
        .or_i       (iOr),
        .not_i      (iNot),
        .mismatch_o (mismatch_w)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        pass_d  = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    mask_d  = '0;
                    step_d  = '0;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (mismatch_w) begin
                    mask_d[step_q] = 1'b1;
                end
                // Pass is judged on the mask including this final check.
                if (step_q == LAST_STEP) begin
                    pass_d  = (mask_d == 4'b0000);
                    state_d = ST_DONE;
                end else begin
                    step_d  = step_q + 2'd1;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        oBusy     = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
        oDone     = (state_q == ST_DONE);
        oA        = oBusy & step_q[0];
        oB        = oBusy & step_q[1];
        oStep     = step_q;
        oPass     = pass_q;
        oFailMask = mask_q;
    end

endmodule

// File: doc/logic_gates_seq.md
# logic_gates_seq

Self-test sequencer for the two-input gate unit (`logic_gates_2`: iA, iB → oAnd, oOr, oNot).
- On a start request it drives the four input combinations in turn and waits a programmable settle time after each.
- It samples the unit's outputs, compares them against the expected truth table, and reports a per-combination fail mask and an overall pass flag.
- It sits between the board-level start button or debug controller and the gate unit, replacing hand-written stimulus.

## Interface
Parameters:
- SETTLE_CYCLES, 4, clock cycles inputs are held before outputs are checked; legal range ≥ 1.

Ports:
- iClk  in  1  system clock; all state changes on rising edge.
- iRst  in  1  reset, synchronous and active-high.
- iStart  in  1  run request; sampled only in IDLE.
- iAnd  in  1  gate unit oAnd.
- iOr  in  1  gate unit oOr.
- iNot  in  1  gate unit oNot (expected ~A).
- oA  out  1  drives gate unit iA.
- oB  out  1  drives gate unit iB.
- oStep  out  2  current combination index.
- oBusy  out  1  high while a run is in progress.
- oDone  out  1  one-cycle pulse at run end.
- oPass  out  1  result of last completed run; holds until the next run completes.
- oFailMask  out  4  bit k set means combination k mismatched.

## Operation
States: IDLE, SETTLE, CHECK, DONE.
- **Step mapping:** oA = oStep[0], oB = oStep[1]. The sequence is (A,B) = 00, 10, 01, 11.
- **IDLE:**
  - If iStart = 1: clear oFailMask, set step = 0 and cnt = 0, go to SETTLE.
  - Otherwise stay in IDLE.
- **SETTLE:** cnt increments each cycle. When cnt = SETTLE_CYCLES−1, go to CHECK.
- **CHECK (one cycle):**
  - Compute expected values: and = A&B, or = A|B, not = ~A.
  - Any mismatch sets oFailMask[step].
  - If step = 3, go to DONE; otherwise step+1, cnt = 0, go to SETTLE.
- **DONE (one cycle):** oDone = 1, then go to IDLE.
- **Outputs in DONE and IDLE:**
  - oA and oB return to 0 in DONE and stay 0 in IDLE.
  - oStep holds 3 until the next start.
  - oFailMask holds until the next start.
- **Busy rules:**
  - oBusy = 1 in SETTLE and CHECK; 0 in IDLE and DONE.
  - iStart is ignored outside IDLE, including in the DONE cycle.
- **Width rules:**
  - cnt is $clog2(SETTLE_CYCLES+1) bits wide and never wraps.
  - step is 2 bits and never wraps past 3.

## Timing
- **Reset (iRst = 1 at an edge):**
  - State → IDLE.
  - oA, oB, oStep, oBusy, oDone, oPass, oFailMask all 0.
  - Reset wins over iStart in the same cycle.
- Let E0 be the edge where iStart is sampled in IDLE. From E0+1: oBusy = 1, oA/oB = 00.
- Each step occupies SETTLE_CYCLES+1 cycles: SETTLE_CYCLES in SETTLE plus 1 in CHECK.
- Gate outputs are sampled at the edge that leaves CHECK. The gate unit must settle within SETTLE_CYCLES cycles.
- **Run end:**
  - oDone is high in the cycle following edge E0 + 4·(SETTLE_CYCLES+1).
  - oPass (= final mask == 0) updates at the same edge.
  - oBusy falls at that same edge.
- **Total latency,** start to oDone: 4·(SETTLE_CYCLES+1)+1 cycles, i.e. 21 for the default.
- **Abort:** reset mid-run aborts the run. No oDone is produced, oPass is cleared, and the previous result is lost.

## Structure
- Shared package `logic_gates_pkg` holds:
  - the state encoding (IDLE = 0, SETTLE = 1, CHECK = 2, DONE = 3);
  - NUM_STEPS = 4;
  - the expected-output function (A,B) → {and, or, not}, which the bench reuses.
- One sub-module is natural: `logic_gates_expect`. It is combinational, takes A, B and the three gate outputs, and produces a 1-bit mismatch.
- The top instantiates the sequencer FSM only. The gate unit is external.

## Test plan
- **Healthy run:** good gate model, SETTLE_CYCLES = 4, iStart pulsed for 1 cycle.
  - (oA,oB) = 00, 10, 01, 11, 5 cycles each.
  - oDone at cycle 21, oPass = 1, oFailMask = 4'b0000.
- **iAnd stuck-at-0:** oFailMask = 4'b1000, oPass = 0.
- **iNot stuck-at-1:** mismatches when A = 1, giving oFailMask = 4'b1010, oPass = 0.
- **iStart during a run:** iStart held high for the whole run, then pulsed in the DONE cycle.
  - Exactly one oDone per run.
  - A new run starts only from an IDLE-cycle start and clears the previous mask.
- **Reset mid-run:** iRst at cycle 7 of a run.
  - Next cycle: all outputs 0, state IDLE, no oDone.
  - A following start completes normally with oPass = 1.
- **Minimum settle:** SETTLE_CYCLES = 1, healthy model.
  - 2 cycles per step, oDone at cycle 9, oPass = 1.
